// File: rtl/mem_pkg.sv
// Shared types and default sizing for the MMIO RAM block.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 100;
    localparam int DEF_IO_REGS = 3;

endpackage

// File: rtl/ram_array.sv
// Word storage: one registered read port and one byte-enabled write port.
// Reads return the pre-write contents; the parent handles collisions.
module ram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 100,
    parameter int IDX_W  = 7
) (
    input  logic                clk,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Registered read and byte-lane write. No reset: the parent clears the array.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/param_mmio_ram.sv
// MMIO RAM with a post-reset clear sequence, write-first forwarding,
// out-of-range detection and shadow registers mirroring the low words.
//
// state | meaning
// CLEAR | zeroing one word per cycle at ptr; requests ignored, busy=1
// READY | normal read/write service
module param_mmio_ram
    import mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int IO_REGS = DEF_IO_REGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ro_port_enable,
    input  logic [ADDR_W-1:0]         ro_port_address,
    output logic [DATA_W-1:0]         ro_port_value,
    output logic                      ro_port_valid,
    input  logic                      wo_port_enable,
    input  logic [ADDR_W-1:0]         wo_port_address,
    input  logic [DATA_W-1:0]         wo_port_value,
    input  logic [DATA_W/8-1:0]       wo_port_be,
    output logic                      busy,
    output logic                      addr_err,
    input  logic                      err_clr,
    output logic [IO_REGS*DATA_W-1:0] io_output,
    output logic [IO_REGS-1:0]        io_update
);

    localparam int BE_W = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Compared with one extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic clearing;
    logic rd_acc, wr_acc, rd_ok, wr_ok, wr_do, err_set;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [DATA_W-1:0] wr_mask, fwd_mask_d;

    logic ram_wr_en;
    logic [IDX_W-1:0] ram_wr_idx;
    logic [BE_W-1:0] ram_wr_be;
    logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

    logic valid_q, oor_q;
    logic [DATA_W-1:0] fwd_mask_q, fwd_data_q, hold_q;

    logic [IO_REGS-1:0][DATA_W-1:0] shadow_q;
    logic [IO_REGS-1:0] upd_q;
    logic err_q;

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state, request acceptance and array port steering.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clearing    = (state_q == CLEAR);
        rd_acc      = (state_q == READY) && ro_port_enable;
        wr_acc      = (state_q == READY) && wo_port_enable;
        rd_ok       = ({1'b0, ro_port_address} < DEPTH_X);
        wr_ok       = ({1'b0, wo_port_address} < DEPTH_X);
        rd_idx      = ro_port_address[IDX_W-1:0];
        wr_idx      = wo_port_address[IDX_W-1:0];
        wr_do       = wr_acc && wr_ok && (|wo_port_be);
        err_set     = (rd_acc && !rd_ok) || (wr_acc && !wr_ok);
        ram_wr_en   = wr_do;
        ram_wr_idx  = wr_idx;
        ram_wr_be   = wo_port_be;
        ram_wr_data = wo_port_value;
        wr_mask     = '0;
        for (int b = 0; b < BE_W; b++) begin
            wr_mask[8*b +: 8] = {8{wo_port_be[b]}};
        end
        fwd_mask_d = (rd_acc && rd_ok && wr_acc && wr_ok && (rd_idx == wr_idx)) ? wr_mask : '0;
        if (clearing) begin
            ram_wr_en   = 1'b1;
            ram_wr_idx  = ptr_q;
            ram_wr_be   = '1;
            ram_wr_data = '0;
            if (ptr_q == LAST_IDX) begin
                state_d = READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (rd_acc && rd_ok),
        .rd_idx  (rd_idx),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_idx  (ram_wr_idx),
        .wr_be   (ram_wr_be),
        .wr_data (ram_wr_data)
    );

    // Read-side bookkeeping: which source supplies the word returned next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            oor_q      <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            valid_q    <= rd_acc;
            oor_q      <= rd_acc && !rd_ok;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= wo_port_value;
            hold_q     <= ro_port_value;
        end
    end

    // Returned word: zero when out of range, merged with a colliding write, held otherwise.
    always_comb begin
        ro_port_value = hold_q;
        if (valid_q) begin
            if (oor_q) begin
                ro_port_value = '0;
            end else begin
                ro_port_value = (ram_rd_data & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);
            end
        end
    end

    // Shadow copies of the low words and their write-strobe pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            upd_q    <= '0;
        end else begin
            upd_q <= '0;
            for (int k = 0; k < IO_REGS; k++) begin
                if (clearing) begin
                    if (ptr_q == IDX_W'(k)) begin
                        shadow_q[k] <= '0;
                    end
                end else if (wr_do && (wr_idx == IDX_W'(k))) begin
                    shadow_q[k] <= (shadow_q[k] & ~wr_mask) | (wo_port_value & wr_mask);
                    upd_q[k]    <= 1'b1;
                end
            end
        end
    end

    // Sticky range-error flag; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign ro_port_valid = valid_q;
    assign busy          = (state_q == CLEAR);
    assign addr_err      = err_q;
    assign io_output     = shadow_q;
    assign io_update     = upd_q;

endmodule
